// File: rtl/speck_pkg.sv
// Shared widths, round count and FSM encoding for the SPECK128/128 decrypt sequencer.
package speck_pkg;
  localparam int WORD_W          = 64;
  localparam int BLOCK_W         = 128;
  localparam int SPECK128_ROUNDS = 32;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_ROUND = 3'd2,
    ST_DONE       = 3'd3,
    ST_ERROR      = 3'd4
  } seq_state_e;
endpackage

// File: rtl/speck_subkey_rf.sv
// Round subkey storage: one write port, one combinational read port, cleared on reset.
module speck_subkey_rf
  import speck_pkg::*;
#(
  parameter int DEPTH = SPECK128_ROUNDS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (32'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (32'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/speck_decrypt_sequencer.sv
// Multi-round controller driving an external SPECK128/128 decryption round core,
// applying subkeys from the last round down to round 0.
module speck_decrypt_sequencer
  import speck_pkg::*;
#(
  parameter int ROUNDS  = SPECK128_ROUNDS,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_wr_en,
  input  logic [4:0]         key_wr_addr,
  input  logic [WORD_W-1:0]  key_wr_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic [4:0]         round_idx,
  output logic               error,
  input  logic               err_clr,
  output logic               core_start,
  output logic [WORD_W-1:0]  core_subkey,
  output logic [BLOCK_W-1:0] core_ciphertext,
  input  logic [BLOCK_W-1:0] core_plaintext,
  input  logic               core_finished,
  input  logic [3:0]         core_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [4:0]         idx_q, idx_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               error_q, error_d;
  logic               live_q;
  logic               rf_we;
  logic [WORD_W-1:0]  rf_rdata;

  // The key file is frozen for the whole transaction, including ERROR.
  assign rf_we = key_wr_en && (state_q == ST_IDLE);

  speck_subkey_rf #(.DEPTH(ROUNDS)) u_subkey_rf (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (rf_we),
    .wr_addr_i (key_wr_addr),
    .wr_data_i (key_wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rf_rdata)
  );

  // live_q keeps in_ready low during reset and for the first cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && live_q) begin
          data_d  = in_data;
          idx_d   = 5'(ROUNDS - 1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_state == 4'd0) begin
          tmo_d   = '0;
          state_d = ST_WAIT_ROUND;
        end
      end
      ST_WAIT_ROUND: begin
        tmo_d = tmo_q + TW'(1);
        // A finish arriving on the timeout cycle still counts as a good round.
        if (core_finished) begin
          data_d = core_plaintext;
          if (idx_q == 5'd0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - 5'd1;
            state_d = ST_ISSUE;
          end
        end else if ((32'(tmo_q) + 32'd1) >= TIMEOUT) begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (err_clr) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    out_data   = '0;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = live_q;
        busy     = 1'b0;
      end
      ST_ISSUE: core_start = (core_state == 4'd0);
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = data_q;
      end
      default: ;
    endcase
  end

  assign round_idx       = idx_q;
  assign error           = error_q;
  assign core_subkey     = rf_rdata;
  assign core_ciphertext = data_q;

endmodule
